// File: rtl/branch_ctrl.sv
// Branch redirect sequencer: captures a taken branch in EX, holds the redirect until fetch accepts it, then drains wrong-path fetches.
// Optional performance counters are enabled by defining BRANCH_CTRL_PERF_EN.
module branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_valid,
    input  logic            i_br_en,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_mem_stall,
    input  logic            i_fetch_ready,
    input  logic            i_cnt_clr,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush_if,
    output logic            o_flush_id,
    output logic            o_busy,
    output logic [31:0]     o_taken_cnt,
    output logic [31:0]     o_bubble_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              busy_q, busy_d;
    logic              take;
    logic              flush;

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        redirect_pc_d = redirect_pc_q;
        take          = 1'b0;
        flush         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stalled branch stays in EX and is taken once the stall drops.
                take  = i_ex_valid & i_br_en & ~i_mem_stall;
                flush = take;
                if (take) begin
                    redirect_pc_d = i_br_target;
                    state_d       = ST_PEND;
                end
            end
            ST_PEND: begin
                flush = 1'b1;
                if (i_fetch_ready) begin
                    if (DRAIN_LOAD == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        drain_cnt_d = DRAIN_LOAD;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                flush = 1'b1;
                if (drain_cnt_q <= 4'd1) begin
                    drain_cnt_d = 4'd0;
                    state_d     = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = 4'd0;
            end
        endcase
        redirect_valid_d = (state_d == ST_PEND);
        busy_d           = (state_d == ST_PEND) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q          <= ST_IDLE;
            drain_cnt_q      <= 4'd0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            drain_cnt_q      <= drain_cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            busy_q           <= busy_d;
        end
    end

    assign o_redirect_valid = redirect_valid_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_busy           = busy_q;
    assign o_flush_if       = flush;
    assign o_flush_id       = flush;

`ifdef BRANCH_CTRL_PERF_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Clear beats a same-cycle increment; both counters wrap naturally.
    always_comb begin
        taken_cnt_d  = taken_cnt_q + {31'd0, take};
        bubble_cnt_d = bubble_cnt_q + {31'd0, flush};
        if (i_cnt_clr) begin
            taken_cnt_d  = 32'd0;
            bubble_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            taken_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            taken_cnt_q  <= taken_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_taken_cnt  = taken_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = i_cnt_clr;
    assign o_taken_cnt    = 32'd0;
    assign o_bubble_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a DRAIN_CYCLES=1 instance driven from a vector table, plus a DRAIN_CYCLES=2 instance for counter sequences.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst, ev, be, st, rdy, clr;
    logic [31:0] tgt;

    logic        rv1, fi1, fd1, busy1;
    logic [31:0] pc1, tc1, bc1;
    logic        rv2, fi2, fd2, busy2;
    logic [31:0] pc2, tc2, bc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.XLEN(32), .DRAIN_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_ex_valid(ev), .i_br_en(be), .i_br_target(tgt),
        .i_mem_stall(st), .i_fetch_ready(rdy), .i_cnt_clr(clr),
        .o_redirect_valid(rv1), .o_redirect_pc(pc1), .o_flush_if(fi1), .o_flush_id(fd1),
        .o_busy(busy1), .o_taken_cnt(tc1), .o_bubble_cnt(bc1)
    );

    branch_ctrl #(.XLEN(32), .DRAIN_CYCLES(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_ex_valid(ev), .i_br_en(be), .i_br_target(tgt),
        .i_mem_stall(st), .i_fetch_ready(rdy), .i_cnt_clr(clr),
        .o_redirect_valid(rv2), .o_redirect_pc(pc2), .o_flush_if(fi2), .o_flush_id(fd2),
        .o_busy(busy2), .o_taken_cnt(tc2), .o_bubble_cnt(bc2)
    );

    typedef struct {
        logic        rst, ev, be;
        logic [31:0] tgt;
        logic        st, rdy;
        logic        rv;
        logic [31:0] pc;
        logic        fl, busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic b, logic [31:0] t, logic s, logic y,
                                logic xrv, logic [31:0] xpc, logic xfl, logic xbusy);
        vec_t v;
        v.rst = r; v.ev = e; v.be = b; v.tgt = t; v.st = s; v.rdy = y;
        v.rv = xrv; v.pc = xpc; v.fl = xfl; v.busy = xbusy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(string tag, logic xrv, logic [31:0] xpc, logic xfl, logic xbusy);
        chk({tag, " rv"}, {31'd0, rv1}, {31'd0, xrv});
        chk({tag, " pc"}, pc1, xpc);
        chk({tag, " flush_if"}, {31'd0, fi1}, {31'd0, xfl});
        chk({tag, " flush_id"}, {31'd0, fd1}, {31'd0, xfl});
        chk({tag, " busy"}, {31'd0, busy1}, {31'd0, xbusy});
    endtask

    task automatic chk2(string tag, logic xrv, logic xfl, logic xbusy);
        chk({tag, " rv"}, {31'd0, rv2}, {31'd0, xrv});
        chk({tag, " flush"}, {31'd0, fi2 & fd2}, {31'd0, xfl});
        chk({tag, " busy"}, {31'd0, busy2}, {31'd0, xbusy});
    endtask

    initial begin
        logic [31:0] exp_tc, exp_bc, exp_bc1;
`ifdef BRANCH_CTRL_PERF_EN
        exp_tc = 32'd3; exp_bc = 32'd12; exp_bc1 = 32'd1;
`else
        exp_tc = 32'd0; exp_bc = 32'd0; exp_bc1 = 32'd0;
`endif
        // Test 2: simple taken branch, fetch always ready
        tbl.push_back(mk(0,1,1,32'h100,     0,1, 0,32'h0,       1,0));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 1,32'h100,     1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 0,32'h100,     1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 0,32'h100,     0,0));
        // Test 3: fetch holds off four cycles; EX inputs ignored in PEND
        tbl.push_back(mk(0,1,1,32'h80000004,0,0, 0,32'h100,     1,0));
        tbl.push_back(mk(0,0,0,32'h0,       0,0, 1,32'h80000004,1,1));
        tbl.push_back(mk(0,1,1,32'hdead0000,0,0, 1,32'h80000004,1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,0, 1,32'h80000004,1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,0, 1,32'h80000004,1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 1,32'h80000004,1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,0, 0,32'h80000004,1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,0, 0,32'h80000004,0,0));
        // Test 4: stalled branch waits, then is taken when the stall drops
        tbl.push_back(mk(0,1,1,32'h40,      1,1, 0,32'h80000004,0,0));
        tbl.push_back(mk(0,1,1,32'h40,      1,1, 0,32'h80000004,0,0));
        tbl.push_back(mk(0,1,1,32'h40,      1,1, 0,32'h80000004,0,0));
        tbl.push_back(mk(0,1,1,32'h40,      0,1, 0,32'h80000004,1,0));
        tbl.push_back(mk(0,0,0,32'h0,       1,1, 1,32'h40,      1,1));
        tbl.push_back(mk(0,0,0,32'h0,       1,1, 0,32'h40,      1,1));
        // back-to-back take in the first IDLE cycle
        tbl.push_back(mk(0,1,1,32'h500,     0,1, 0,32'h40,      1,0));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 1,32'h500,     1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 0,32'h500,     1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 0,32'h500,     0,0));
        // Test 5: reset during PEND aborts the redirect
        tbl.push_back(mk(0,1,1,32'h200,     0,0, 0,32'h500,     1,0));
        tbl.push_back(mk(0,0,0,32'h0,       0,0, 1,32'h200,     1,1));
        tbl.push_back(mk(1,0,0,32'h0,       0,1, 1,32'h200,     1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 0,32'h0,       0,0));
        tbl.push_back(mk(0,1,1,32'h300,     0,1, 0,32'h0,       1,0));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 1,32'h300,     1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 0,32'h300,     1,1));
        tbl.push_back(mk(0,0,0,32'h0,       0,1, 0,32'h300,     0,0));
        // br_en without ex_valid is not a take
        tbl.push_back(mk(0,0,1,32'h700,     0,1, 0,32'h300,     0,0));

        rst = 1'b1; ev = 1'b0; be = 1'b0; st = 1'b0; rdy = 1'b0; clr = 1'b0; tgt = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Test 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            #2;
            chk1($sformatf("idle%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; ev = tbl[i].ev; be = tbl[i].be; tgt = tbl[i].tgt;
            st = tbl[i].st; rdy = tbl[i].rdy;
            #2;
            chk1($sformatf("vec%0d", i), tbl[i].rv, tbl[i].pc, tbl[i].fl, tbl[i].busy);
            @(negedge clk);
        end

        // Test 6: DRAIN_CYCLES=2, three branches with 1-cycle PEND
        rst = 1'b1; ev = 1'b0; be = 1'b0; st = 1'b0; rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 3; b++) begin
            ev = 1'b1; be = 1'b1; tgt = 32'h1000 + 32'(b);
            #2; chk2($sformatf("p6 take%0d", b), 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            ev = 1'b0; be = 1'b0;
            #2; chk2($sformatf("p6 pend%0d", b), 1'b1, 1'b1, 1'b1);
            chk($sformatf("p6 pc%0d", b), pc2, 32'h1000 + 32'(b));
            @(negedge clk);
            #2; chk2($sformatf("p6 drainA%0d", b), 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            #2; chk2($sformatf("p6 drainB%0d", b), 1'b0, 1'b1, 1'b1);
            @(negedge clk);
        end
        #2;
        chk2("p6 idle", 1'b0, 1'b0, 1'b0);
        chk("taken_cnt", tc2, exp_tc);
        chk("bubble_cnt", bc2, exp_bc);
        @(negedge clk);
        // clear coincident with a take wins over the increment
        ev = 1'b1; be = 1'b1; tgt = 32'h2000; clr = 1'b1;
        @(negedge clk);
        ev = 1'b0; be = 1'b0; clr = 1'b0;
        #2;
        chk("taken_cnt clr", tc2, 32'd0);
        chk("bubble_cnt clr", bc2, 32'd0);
        @(negedge clk);
        #2;
        chk("bubble_cnt after clr", bc2, exp_bc1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences the front end after the EX-stage branch unit resolves a taken branch or jump.
- Captures the target, holds a redirect request to the fetch unit until it is accepted, then drains wrong-path fetches for a fixed number of cycles.
- While active, generates the IF/ID flush signals and a busy flag.
- Sits between the EX-stage branch comparator output and the fetch unit's redirect port.

Parameters:
- XLEN, 32, width of PC and target.
- DRAIN_CYCLES, 1, cycles after redirect acceptance during which fetch output is still wrong-path (0..15).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_ex_valid  input  1  valid instruction in EX.
- i_br_en  input  1  branch taken (conditional met or unconditional jump), from branch unit.
- i_br_target  input  XLEN  resolved target address.
- i_mem_stall  input  1  pipeline freeze; EX does not advance this cycle.
- i_fetch_ready  input  1  fetch unit accepts the redirect this cycle.
- o_redirect_valid  output  1  redirect request to fetch.
- o_redirect_pc  output  XLEN  redirect address; stable while o_redirect_valid=1.
- o_flush_if  output  1  squash IF/ID register on this edge.
- o_flush_id  output  1  squash ID/EX register on this edge.
- o_busy  output  1  controller not idle.
- o_taken_cnt  output  32  taken-branch count (optional feature).
- o_bubble_cnt  output  32  flush-cycle count (optional feature).
- i_cnt_clr  input  1  synchronous clear of counters (optional feature).

Behaviour:
- Reset: state IDLE, drain counter 0, o_redirect_pc=0, all 1-bit outputs 0.
- Reset asserted in any state aborts a pending redirect immediately; no acceptance is reported afterwards.
- take = i_ex_valid & i_br_en & ~i_mem_stall, evaluated only in IDLE.
- IDLE:
  - o_flush_if = o_flush_id = take (combinational, same cycle the branch sits in EX).
  - On take: o_redirect_pc <= i_br_target; state -> PEND.
  - If i_mem_stall=1, nothing is captured; the branch remains in EX and is taken once the stall drops.
- PEND:
  - o_redirect_valid=1; o_flush_if=o_flush_id=1; o_busy=1.
  - o_redirect_pc holds its value.
  - On i_fetch_ready=1: if DRAIN_CYCLES=0, state -> IDLE; else load the drain counter with DRAIN_CYCLES and go to DRAIN.
  - Minimum PEND duration is 1 cycle; i_fetch_ready is ignored outside PEND.
- DRAIN:
  - o_redirect_valid=0; o_flush_if=o_flush_id=1; o_busy=1.
  - The counter decrements each cycle; state -> IDLE in the cycle after the counter reaches 1.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- In PEND and DRAIN, i_br_en/i_ex_valid are ignored. EX holds bubbles by construction because ID/EX is flushed.
- i_mem_stall does not affect PEND or DRAIN progress.
- Latency:
  - Capture edge to o_redirect_valid: 1 cycle.
  - A taken branch costs 1 + PEND cycles + DRAIN_CYCLES bubble cycles.
- Back-to-back: a new take can be captured in the first IDLE cycle after DRAIN or PEND exits.
- o_redirect_pc is passed unaltered; alignment is not checked here.
- State encoding is 2 bits; the unused code returns to IDLE on the next edge with all outputs 0.

Optional Feature:
- Macro: BRANCH_CTRL_PERF_EN.
- Defined:
  - o_taken_cnt increments on every take.
  - o_bubble_cnt increments every cycle o_flush_if=1 (including the take cycle).
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both are cleared by i_rst or i_cnt_clr; i_cnt_clr has priority over an increment in the same cycle.
- Undefined: counter registers are absent, o_taken_cnt=o_bubble_cnt=0 constantly, and i_cnt_clr is ignored.

Test Plan:
1. Reset, then IDLE with i_br_en=0 for 10 cycles -> all outputs 0, o_redirect_pc=0.
2. DRAIN_CYCLES=1, fetch_ready tied 1. take with target 0x00000100 at cycle N:
   - flush_if/id=1 at N.
   - redirect_valid=1, pc=0x100 at N+1.
   - flush only at N+2.
   - IDLE and busy=0 at N+3.
3. fetch_ready held 0 for 4 cycles after capture of 0x80000004 -> redirect_valid and pc=0x80000004 stay stable all 4 cycles; exit follows the first cycle with fetch_ready=1.
4. i_br_en=1 with i_mem_stall=1 for 3 cycles, then stall drops -> no flush/redirect during stall; capture occurs in the cycle the stall drops.
5. Assert i_rst during PEND with pc=0x200 -> next cycle all outputs 0, state IDLE. A new branch to 0x300 afterwards redirects to 0x300.
6. BRANCH_CTRL_PERF_EN, DRAIN_CYCLES=2, 3 branches with 1-cycle PEND -> o_taken_cnt=3, o_bubble_cnt=12. i_cnt_clr asserted coincident with a take -> both counters 0.
